// File: rtl/lcd_16x2_ctrl.sv
// Autonomous HD44780 16x2 LCD controller: power-up wait, init command sequence,
// then continuous refresh of both lines from a 32-byte character buffer.
module lcd_16x2_ctrl #(
    parameter int unsigned PWRUP_WAIT_CYC = 750000,
    parameter int unsigned SETUP_CYC      = 4,
    parameter int unsigned EN_PULSE_CYC   = 16,
    parameter int unsigned CMD_WAIT_CYC   = 2000,
    parameter int unsigned CLR_WAIT_CYC   = 82000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       WR_EN,
    input  logic [4:0] WR_ADDR,
    input  logic [7:0] WR_DATA,
    input  logic       BLON_EN,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_ON,
    output logic       LCD_BLON,
    output logic       READY,
    output logic       FRAME_DONE
);

    localparam int unsigned MAX_A   = (PWRUP_WAIT_CYC > CLR_WAIT_CYC) ? PWRUP_WAIT_CYC : CLR_WAIT_CYC;
    localparam int unsigned MAX_B   = (CMD_WAIT_CYC > MAX_A) ? CMD_WAIT_CYC : MAX_A;
    localparam int unsigned MAX_C   = (SETUP_CYC > MAX_B) ? SETUP_CYC : MAX_B;
    localparam int unsigned CNT_MAX = (EN_PULSE_CYC > MAX_C) ? EN_PULSE_CYC : MAX_C;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_WAIT_CYC - 1);

    localparam logic [5:0] LINE2_CMD_IDX = 6'd17;
    localparam logic [5:0] LAST_REF_IDX  = 6'd33;

    typedef enum logic [1:0] {
        PH_PWRUP,
        PH_INIT,
        PH_REFRESH
    } phase_t;

    typedef enum logic [1:0] {
        XF_SETUP,
        XF_PULSE,
        XF_WAIT
    } xfer_t;

    phase_t           r_phase;
    xfer_t            r_xfer;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_wait_last;
    logic [5:0]       r_idx;
    logic             r_is_last;
    logic [7:0]       r_data;
    logic             r_rs;
    logic             r_en;
    logic             r_ready;
    logic             r_frame_done;
    logic             r_blon;
    logic [7:0]       r_buf [32];

    logic [7:0]       w_item_data;
    logic             w_item_rs;
    logic [4:0]       w_buf_idx;
    logic             w_load;

    // NOTE: a memory only gets an async reset when its contents are defined after
    // reset; here every byte must read as a space, so it is built from flops.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 32; i++) begin
                r_buf[i] <= 8'h20;
            end
        end else if (WR_EN) begin
            r_buf[WR_ADDR] <= WR_DATA;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_blon <= 1'b0;
        end else begin
            r_blon <= BLON_EN;
        end
    end

    // Byte to send next, selected by sequence phase and item index.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_item_data = 8'h00;
        w_item_rs   = 1'b0;
        w_buf_idx   = 5'd0;
        if (r_phase == PH_REFRESH) begin
            if (r_idx == 6'd0) begin
                w_item_data = 8'h80;
            end else if (r_idx == LINE2_CMD_IDX) begin
                w_item_data = 8'hC0;
            end else begin
                w_buf_idx   = (r_idx < LINE2_CMD_IDX) ? 5'(r_idx - 6'd1) : 5'(r_idx - 6'd2);
                w_item_data = r_buf[w_buf_idx];
                w_item_rs   = 1'b1;
            end
        end else begin
            case (r_idx[1:0])
                2'd0:    w_item_data = 8'h38;
                2'd1:    w_item_data = 8'h0C;
                2'd2:    w_item_data = 8'h01;
                default: w_item_data = 8'h06;
            endcase
        end
    end

    assign w_load = (r_phase == PH_PWRUP) ? (r_cnt == PWRUP_LAST)
                                          : ((r_xfer == XF_WAIT) && (r_cnt == r_wait_last));

    // NOTE: state uses non-blocking assignments; the buffer read above therefore sees
    // the pre-edge byte, so a write landing on the load edge is sent next frame.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_phase      <= PH_PWRUP;
            r_xfer       <= XF_SETUP;
            r_cnt        <= '0;
            r_wait_last  <= CMD_LAST;
            r_idx        <= 6'd0;
            r_is_last    <= 1'b0;
            r_data       <= 8'h00;
            r_rs         <= 1'b0;
            r_en         <= 1'b0;
            r_ready      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_load) begin
                r_data      <= w_item_data;
                r_rs        <= w_item_rs;
                r_en        <= 1'b0;
                r_xfer      <= XF_SETUP;
                r_cnt       <= '0;
                r_wait_last <= (!w_item_rs && (w_item_data == 8'h01)) ? CLR_LAST : CMD_LAST;
                r_is_last   <= (r_phase == PH_REFRESH) && (r_idx == LAST_REF_IDX);
                case (r_phase)
                    PH_PWRUP: begin
                        r_phase <= PH_INIT;
                        r_idx   <= 6'd1;
                    end
                    PH_INIT: begin
                        if (r_idx == 6'd3) begin
                            r_phase <= PH_REFRESH;
                            r_idx   <= 6'd0;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                    default: begin
                        r_ready <= 1'b1;
                        r_idx   <= (r_idx == LAST_REF_IDX) ? 6'd0 : r_idx + 6'd1;
                    end
                endcase
            end else if (r_phase == PH_PWRUP) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                case (r_xfer)
                    XF_SETUP: begin
                        if (r_cnt == SETUP_LAST) begin
                            r_xfer <= XF_PULSE;
                            r_en   <= 1'b1;
                            r_cnt  <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    XF_PULSE: begin
                        if (r_cnt == PULSE_LAST) begin
                            r_xfer       <= XF_WAIT;
                            r_en         <= 1'b0;
                            r_cnt        <= '0;
                            r_frame_done <= r_is_last && (r_wait_last == '0);
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                    default: begin
                        // Flag the final WAIT cycle of the last character one edge early.
                        r_cnt        <= r_cnt + CNT_ONE;
                        r_frame_done <= r_is_last && ((r_cnt + CNT_ONE) == r_wait_last);
                    end
                endcase
            end
        end
    end

    assign LCD_DATA   = r_data;
    assign LCD_RS     = r_rs;
    assign LCD_RW     = 1'b0;
    assign LCD_EN     = r_en;
    assign LCD_ON     = 1'b1;
    assign LCD_BLON   = r_blon;
    assign READY      = r_ready;
    assign FRAME_DONE = r_frame_done;

endmodule

// File: doc/lcd_16x2_ctrl.md
Name: lcd_16x2_ctrl

Overview:
Autonomous controller for the board's HD44780-compatible 16x2 character LCD.
- After reset it runs the power-up and initialisation command sequence.
- It then refreshes both display lines continuously from an internal 32-byte character buffer.
- User logic writes characters into the buffer through a single-cycle write port; LCD timing stays inside this block.
- The LCD is write-only: LCD_RW is held at 0 and LCD_DATA is driven as an output.

Parameters:
PWRUP_WAIT_CYC, 750000, cycles to wait after reset before the first command (15 ms at 50 MHz)
SETUP_CYC, 4, cycles LCD_RS/LCD_DATA are stable before LCD_EN rises
EN_PULSE_CYC, 16, LCD_EN high width in cycles
CMD_WAIT_CYC, 2000, cycles with LCD_EN low after each ordinary transfer (40 us)
CLR_WAIT_CYC, 82000, cycles with LCD_EN low after the clear-display command 0x01 (1.64 ms)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
WR_EN  in  1  buffer write strobe, one write per cycle
WR_ADDR  in  5  character index: 0-15 = line 1, 16-31 = line 2
WR_DATA  in  8  character code
BLON_EN  in  1  backlight request
LCD_DATA  out  8  LCD data bus
LCD_RS  out  1  0 = command, 1 = data
LCD_RW  out  1  constant 0
LCD_EN  out  1  LCD strobe
LCD_ON  out  1  constant 1
LCD_BLON  out  1  registered copy of BLON_EN
READY  out  1  high once initialisation has completed
FRAME_DONE  out  1  one-cycle pulse at the end of each full 34-transfer refresh frame

Behaviour:
- Reset values (asynchronous): LCD_DATA=0x00, LCD_RS=0, LCD_EN=0, LCD_BLON=0, READY=0, FRAME_DONE=0, all 32 buffer bytes = 0x20 (space), FSM in PWRUP. LCD_RW=0 and LCD_ON=1 at all times.
- Outer FSM:
  - PWRUP: count PWRUP_WAIT_CYC cycles, then go to INIT.
  - INIT: issue commands 0x38, 0x0C, 0x01, 0x06 in that order (RS=0).
  - REFRESH: loop forever over 34 transfers: cmd 0x80, chars 0-15 (RS=1), cmd 0xC0, chars 16-31 (RS=1).
- Transfer sub-FSM, used for every command and character byte:
  - SETUP: LCD_DATA and LCD_RS are loaded on the first cycle, then held for SETUP_CYC cycles with LCD_EN=0.
  - PULSE: LCD_EN=1 for EN_PULSE_CYC cycles.
  - WAIT: LCD_EN=0 for CMD_WAIT_CYC cycles, or CLR_WAIT_CYC cycles when the byte is the 0x01 command.
  - LCD_DATA and LCD_RS hold their value until the next SETUP load.
  - Ordinary transfer length = SETUP_CYC + EN_PULSE_CYC + CMD_WAIT_CYC cycles. Transfers are back-to-back with no idle cycles.
- READY goes high on the cycle the first 0x80 SETUP starts. It stays high until reset.
- FRAME_DONE pulses for one cycle on the last WAIT cycle of char 31. The next cycle starts the 0x80 SETUP.
- Buffer write: when WR_EN=1, buf[WR_ADDR] <= WR_DATA at the clock edge. Writes are accepted in every FSM state, including PWRUP and INIT.
- Fetch: a character is sampled from the buffer on its SETUP load cycle.
  - A write landing on the same edge as that load, to the same index, is not seen; the old byte is sent.
  - The new byte appears on the next refresh frame.
  - A write during PULSE/WAIT of the same index does not change the LCD_DATA currently being driven.
- Counters are sized from the parameters. A parameter value of 0 is illegal; no wrap-around handling is required.
- RESET_N asserted mid-transfer, including with LCD_EN=1: LCD_EN drops asynchronously, the buffer clears to spaces, and the full PWRUP + INIT sequence reruns on release.
- LCD_BLON follows BLON_EN with 1-cycle latency, independent of the FSM.

Test Plan:
All scenarios use PWRUP_WAIT_CYC=100, SETUP_CYC=2, EN_PULSE_CYC=4, CMD_WAIT_CYC=10, CLR_WAIT_CYC=50.
- Init sequence: release reset at cycle 0 -> LCD_EN edges capture bytes 0x38, 0x0C, 0x01, 0x06 with RS=0; first LCD_EN rise at cycle 102; READY rises at cycle 204.
- Timing check: on every transfer, LCD_EN is high exactly 4 cycles and LCD_DATA/LCD_RS are stable from SETUP through the end of WAIT; the gap after 0x01 is 50 cycles low, all other gaps are 10.
- Default frame: no writes -> captured sequence is 0x80, 16x 0x20 (RS=1), 0xC0, 16x 0x20; FRAME_DONE pulses every 544 cycles.
- Buffer writes: write 0x48 to addr 0 and 0x21 to addr 31 before READY -> first frame sends 0x48 first on line 1 and 0x21 last on line 2.
- Collision: write 0x41 to addr 5 on the exact SETUP load cycle of char 5 -> 0x20 is sent this frame, 0x41 next frame.
- Reset mid-pulse: assert RESET_N=0 while LCD_EN=1 -> LCD_EN=0 and READY=0 immediately with no clock edge; after release, buffer reads spaces and init restarts at 0x38.
